// File: rtl/i2c_slave_regfile.sv
// I2C target with a 16x8 register file: decodes oversampled SCL/SDA into pointer-addressed
// register writes and reads, with auto-incrementing pointer and a core-side read port.
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] reg_rd_addr,
  output logic [7:0] reg_rd_data
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, PTR, ACK_PTR, WR, ACK_WR, RD, MACK, WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic        sclMeta_q, sclSync_q, sclPrev_q;
  logic        sdaMeta_q, sdaSync_q, sdaPrev_q;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic        phase_q, phase_d;
  logic        sdaOe_q, sdaOe_d;
  logic        busy_q, busy_d;
  logic        wrStrobe_q, wrStrobe_d;
  logic [3:0]  wrAddr_q, wrAddr_d;
  logic [7:0]  wrData_q, wrData_d;
  logic [7:0]  regs_q [16];
  logic        regWe;

  logic        sclRise, sclFall, startDet, stopDet;
  logic [7:0]  shiftIn;
  logic [7:0]  rdByte;

  // Sync flops idle high so a reset on an idle bus never fakes a START/STOP
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclMeta_q <= scl_in;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
      sdaMeta_q <= sda_in;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaSync_q;
    end
  end

  assign sclRise  = sclSync_q & ~sclPrev_q;
  assign sclFall  = ~sclSync_q & sclPrev_q;
  assign startDet = sclSync_q & sdaPrev_q & ~sdaSync_q;
  assign stopDet  = sclSync_q & ~sdaPrev_q & sdaSync_q;
  assign shiftIn  = {shift_q[6:0], sdaSync_q};
  assign rdByte   = regs_q[ptr_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      sdaOe_q    <= 1'b0;
      busy_q     <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      sdaOe_q    <= sdaOe_d;
      busy_q     <= busy_d;
      wrStrobe_q <= wrStrobe_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
    end
  end

  // Written on the same edge that raises wr_strobe, so the new byte is visible during the strobe
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (regWe) begin
      regs_q[ptr_q] <= shiftIn;
    end
  end

  // phase_q: in ACK states marks "ACK driven, waiting for closing fall";
  // in MACK marks "master ACKed, waiting for the fall to load the next byte"
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    sdaOe_d    = sdaOe_q;
    busy_d     = busy_q;
    wrStrobe_d = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    regWe      = 1'b0;

    if (stopDet) begin
      state_d = IDLE;
      sdaOe_d = 1'b0;
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else if (startDet) begin
      state_d  = DEV;
      bitCnt_d = '0;
      shift_d  = '0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b0;
      phase_d  = 1'b0;
    end else begin
      case (state_q)
        DEV: begin
          if (sclRise) begin
            shift_d  = shiftIn;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (shiftIn[7:1] == DEV_ADDR) begin
                state_d = ACK_DEV;
                rw_d    = shiftIn[0];
                busy_d  = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end

        PTR, WR: begin
          if (sclRise) begin
            shift_d  = shiftIn;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              if (state_q == PTR) begin
                ptr_d   = shiftIn[3:0];
                state_d = ACK_PTR;
              end else begin
                regWe      = 1'b1;
                wrStrobe_d = 1'b1;
                wrAddr_d   = ptr_q;
                wrData_d   = shiftIn;
                ptr_d      = ptr_q + 4'd1;
                state_d    = ACK_WR;
              end
            end
          end
        end

        ACK_DEV, ACK_PTR, ACK_WR: begin
          if (sclFall) begin
            if (!phase_q) begin
              sdaOe_d = 1'b1;
              phase_d = 1'b1;
            end else begin
              phase_d  = 1'b0;
              bitCnt_d = '0;
              if (state_q == ACK_DEV && rw_q) begin
                shift_d = rdByte;
                sdaOe_d = ~rdByte[7];
                state_d = RD;
              end else begin
                sdaOe_d = 1'b0;
                state_d = (state_q == ACK_DEV) ? PTR : WR;
              end
            end
          end
        end

        // The shifter rotates so the bit on SDA is always shift_q[7]
        RD: begin
          if (sclFall) begin
            if (bitCnt_q == 3'd7) begin
              sdaOe_d = 1'b0;
              phase_d = 1'b0;
              state_d = MACK;
            end else begin
              shift_d  = {shift_q[6:0], shift_q[7]};
              sdaOe_d  = ~shift_q[6];
              bitCnt_d = bitCnt_q + 3'd1;
            end
          end
        end

        MACK: begin
          if (!phase_q) begin
            if (sclRise) begin
              if (!sdaSync_q) begin
                ptr_d   = ptr_q + 4'd1;
                phase_d = 1'b1;
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
                sdaOe_d = 1'b0;
              end
            end
          end else if (sclFall) begin
            phase_d  = 1'b0;
            bitCnt_d = '0;
            shift_d  = rdByte;
            sdaOe_d  = ~rdByte[7];
            state_d  = RD;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign sda_oe      = sdaOe_q;
  assign busy        = busy_q;
  assign wr_strobe   = wrStrobe_q;
  assign wr_addr     = wrAddr_q;
  assign wr_data     = wrData_q;
  assign reg_rd_data = regs_q[reg_rd_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: a bit-level I2C master on a wired-AND SDA line, with a
// register/pointer reference model and a write-strobe scoreboard.
module tb_i2c_slave_regfile;

  localparam logic [6:0] DEV = 7'h50;
  localparam int H = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclM = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaBus;
  logic       sda_oe, busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] reg_rd_addr = '0;
  logic [7:0] reg_rd_data;

  int         assertCount = 0;
  int         failCount = 0;
  logic [7:0] modelRegs [16];
  int         modelPtr = 0;
  logic [11:0] expQ [$];
  logic [7:0] wrData [$];

  assign sdaBus = sdaM & ~sda_oe;

  i2c_slave_regfile #(.DEV_ADDR(DEV)) dut (
    .clk(clk), .rst(rst), .scl_in(sclM), .sda_in(sdaBus), .sda_oe(sda_oe),
    .busy(busy), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period starting just after a fall; returns the bus level late in the high phase
  task automatic bitCycle(input logic b, output logic sampled);
    waitClk(H / 2);
    sdaM = b;
    waitClk(H - H / 2);
    sclM = 1'b1;
    waitClk(H - 1);
    sampled = sdaBus;
    waitClk(1);
    sclM = 1'b0;
  endtask

  task automatic busStart();
    if (!sclM) begin
      waitClk(H / 2);
      sdaM = 1'b1;
      waitClk(H);
      sclM = 1'b1;
    end else begin
      sdaM = 1'b1;
    end
    waitClk(H);
    sdaM = 1'b0;
    waitClk(H);
    sclM = 1'b0;
  endtask

  task automatic busStop();
    waitClk(H / 2);
    sdaM = 1'b0;
    waitClk(H / 2);
    sclM = 1'b1;
    waitClk(H);
    sdaM = 1'b1;
    waitClk(H);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bitCycle(b[i], s);
    bitCycle(1'b1, s);
    acked = ~s;
  endtask

  task automatic readByte(input logic mackBit, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bitCycle(1'b1, s);
      d[i] = s;
    end
    bitCycle(mackBit, s);
  endtask

  // Optional pointer write plus the bytes queued in wrData, then an optional read of nRd bytes
  task automatic applyStimulus(input logic doWrite, input logic [6:0] addr, input logic [7:0] ptrByte, input int nRd);
    logic       ack, match;
    logic [7:0] d;
    match = (addr == DEV);
    if (doWrite) begin
      busStart();
      sendByte({addr, 1'b0}, ack);
      checkOutput("devAckW", ack, match);
      if (match) begin
        checkOutput("busyW", busy, 1);
        sendByte(ptrByte, ack);
        checkOutput("ptrAck", ack, 1);
        modelPtr = int'(ptrByte) % 16;
        while (wrData.size() > 0) begin
          d = wrData.pop_front();
          expQ.push_back({modelPtr[3:0], d});
          modelRegs[modelPtr] = d;
          modelPtr = (modelPtr + 1) % 16;
          sendByte(d, ack);
          checkOutput("dataAck", ack, 1);
        end
      end
    end
    if (nRd > 0 && (match || !doWrite)) begin
      busStart();
      sendByte({addr, 1'b1}, ack);
      checkOutput("devAckR", ack, match);
      if (match) begin
        for (int k = 0; k < nRd; k++) begin
          readByte(k == nRd - 1, d);
          checkOutput("rdData", d, modelRegs[modelPtr]);
          if (k < nRd - 1) modelPtr = (modelPtr + 1) % 16;
        end
        checkOutput("busyNack", busy, 0);
        checkOutput("oeNack", sda_oe, 0);
      end
    end
    busStop();
    wrData.delete();
    checkOutput("busyIdle", busy, 0);
    checkOutput("strobesDone", expQ.size(), 0);
  endtask

  task automatic checkReg(input int idx);
    reg_rd_addr = idx[3:0];
    waitClk(1);
    checkOutput($sformatf("reg%0d", idx), reg_rd_data, modelRegs[idx]);
  endtask

  // Every strobe cycle must match the next expected write, so a stretched pulse shows as extra
  always @(negedge clk) begin
    if (rst && wr_strobe) begin
      if (expQ.size() == 0) begin
        checkOutput("strobeExtra", 1, 0);
      end else begin
        logic [11:0] e;
        e = expQ.pop_front();
        checkOutput("wrAddr", wr_addr, e[11:8]);
        checkOutput("wrData", wr_data, e[7:0]);
      end
    end
  end

  initial begin
    waitClk(90000);
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic       ack, s;
    logic [6:0] a;
    logic       doWr;
    int         nRd, nWr;

    for (int i = 0; i < 16; i++) modelRegs[i] = '0;
    waitClk(4);
    checkOutput("rstOe", sda_oe, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstStrobe", wr_strobe, 0);
    checkOutput("rstWrAddr", wr_addr, 0);
    checkOutput("rstWrData", wr_data, 0);
    checkOutput("rstReg0", reg_rd_data, 0);
    rst = 1'b1;
    waitClk(4);

    wrData = '{8'hA5};
    applyStimulus(1'b1, DEV, 8'h03, 0);
    checkReg(3);

    wrData = '{8'h11, 8'h22, 8'h33};
    applyStimulus(1'b1, DEV, 8'h0E, 0);
    checkReg(14);
    checkReg(15);
    checkReg(0);

    applyStimulus(1'b1, DEV, 8'h0E, 3);

    applyStimulus(1'b1, 7'h51, 8'h00, 0);

    // STOP after four data bits discards the partial byte
    busStart();
    sendByte({DEV, 1'b0}, ack);
    checkOutput("midAddrAck", ack, 1);
    sendByte(8'h05, ack);
    checkOutput("midPtrAck", ack, 1);
    modelPtr = 5;
    bitCycle(1'b1, s);
    bitCycle(1'b0, s);
    bitCycle(1'b1, s);
    bitCycle(1'b1, s);
    busStop();
    checkOutput("midOe", sda_oe, 0);
    checkOutput("midBusy", busy, 0);
    checkOutput("midStrobes", expQ.size(), 0);
    checkReg(5);

    // Reset while the target drives a read bit 0 of 0x5A (bit 0 is low, so SDA is pulled)
    wrData = '{8'h5A};
    applyStimulus(1'b1, DEV, 8'h07, 0);
    modelPtr = 7;
    busStart();
    sendByte({DEV, 1'b1}, ack);
    checkOutput("rstRdAck", ack, 1);
    for (int i = 0; i < 7; i++) bitCycle(1'b1, s);
    waitClk(H / 2);
    checkOutput("rdBit0Driven", sda_oe, 1);
    rst = 1'b0;
    waitClk(1);
    rst = 1'b1;
    checkOutput("oeAfterRst", sda_oe, 0);
    checkOutput("busyAfterRst", busy, 0);
    for (int i = 0; i < 16; i++) modelRegs[i] = '0;
    modelPtr = 0;
    expQ.delete();
    waitClk(H);
    sclM = 1'b1;
    waitClk(H);
    sclM = 1'b0;
    wrData = '{8'hC3};
    applyStimulus(1'b1, DEV, 8'h02, 1);
    checkReg(7);

    for (int t = 0; t < 14; t++) begin
      a = DEV;
      if ($urandom_range(0, 9) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == DEV) a = 7'h51;
      end
      doWr = 1'($urandom_range(0, 1));
      nRd  = $urandom_range(0, 3);
      nWr  = $urandom_range(0, 4);
      if (!doWr && nRd == 0) nRd = 1;
      for (int k = 0; k < nWr; k++) wrData.push_back(8'($urandom));
      applyStimulus(doWr, a, 8'($urandom), nRd);
    end

    for (int i = 0; i < 16; i++) checkReg(i);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
